// File: rtl/shift_unit_seq.sv
// Multi-cycle logical/arithmetic shifter, up to STEP bits per clock, valid/ready on both sides.
// Optional rotate-left on func 11 when SHIFT_UNIT_ROTATE_EN is defined; otherwise func 11 is flagged illegal.
module shift_unit_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               src_sel,
    input  logic [1:0]         func,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               shift_busy
);

    localparam int RW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] data_r, data_nx;
    logic             carry_r, carry_nx;
    logic             err_r, err_nx;
    logic             over_r, over_nx;
    logic [1:0]       func_r, func_nx;
    logic [RW-1:0]    rem_r, rem_nx;

    logic [RW-1:0]      k;
    logic [RW-1:0]      amt;
    logic [WIDTH-1:0]   sh_data;
    logic               sh_carry;
    logic               fill;
    logic [2*WIDTH:0]   r_w;
    logic [2*WIDTH:0]   l_w;
    logic [2*WIDTH-1:0] o_w;

    // One step of up to STEP bits; the extra guard bit of each wide vector captures the carry.
    always_comb begin
        k        = (rem_r > RW'(STEP)) ? RW'(STEP) : rem_r;
        fill     = (func_r == 2'b10) & data_r[WIDTH-1];
        r_w      = {{WIDTH{fill}}, data_r, 1'b0} >> k;
        l_w      = {1'b0, data_r, {WIDTH{1'b0}}} << k;
        o_w      = {data_r, data_r} << k;
        sh_data  = r_w[WIDTH:1];
        sh_carry = r_w[0];
        case (func_r)
            2'b01: begin
                sh_data  = l_w[2*WIDTH-1:WIDTH];
                sh_carry = l_w[2*WIDTH];
            end
            2'b11: begin
                sh_data  = o_w[2*WIDTH-1:WIDTH];
                sh_carry = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        data_nx  = data_r;
        carry_nx = carry_r;
        err_nx   = err_r;
        over_nx  = over_r;
        func_nx  = func_r;
        rem_nx   = rem_r;
        amt      = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_nx  = src_sel ? b : a;
                    carry_nx = 1'b0;
                    err_nx   = 1'b0;
                    func_nx  = func;
                    over_nx  = 32'(shamt) > WIDTH;
                    if (func == 2'b11) begin
`ifdef SHIFT_UNIT_ROTATE_EN
                        amt = RW'(32'(shamt) % WIDTH);
`else
                        err_nx = 1'b1;
`endif
                    end else if (32'(shamt) >= WIDTH) begin
                        amt = RW'(WIDTH);
                    end else begin
                        amt = RW'(shamt);
                    end
                    rem_nx   = amt;
                    state_nx = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_nx  = sh_data;
                carry_nx = sh_carry;
                rem_nx   = rem_r - k;
                if (rem_r == k) begin
                    state_nx = DONE;
                    // Logical shifts past WIDTH have pushed out only zero fill by the end.
                    if (over_r && !func_r[1])
                        carry_nx = 1'b0;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            data_r  <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
            over_r  <= 1'b0;
            func_r  <= 2'b00;
            rem_r   <= '0;
        end else begin
            state   <= state_nx;
            data_r  <= data_nx;
            carry_r <= carry_nx;
            err_r   <= err_nx;
            over_r  <= over_nx;
            func_r  <= func_nx;
            rem_r   <= rem_nx;
        end
    end

    assign in_ready   = (state == IDLE);
    assign shift_busy = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign out_data   = out_valid ? data_r : '0;
    assign out_carry  = out_valid & carry_r;
    assign out_err    = out_valid & err_r;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: STEP=1 and STEP=4 instances, vector table, scoreboard and corner sequences.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        src_sel = 1'b0;
    logic [1:0]  func = 2'b00;
    logic [4:0]  shamt = '0;
    logic        iv1 = 1'b0, iv4 = 1'b0, or1 = 1'b0, or4 = 1'b0;
    logic        ir1, ir4, oc1, oc4, oe1, oe4, ov1, ov4, bz1, bz4;
    logic [15:0] od1, od4;
    bit          sel4 = 1'b0;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(16), .SHAMT_W(5), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .src_sel(src_sel), .func(func), .shamt(shamt),
        .in_valid(iv1), .in_ready(ir1), .out_data(od1), .out_carry(oc1), .out_err(oe1),
        .out_valid(ov1), .out_ready(or1), .shift_busy(bz1));

    shift_unit_seq #(.WIDTH(16), .SHAMT_W(5), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .src_sel(src_sel), .func(func), .shamt(shamt),
        .in_valid(iv4), .in_ready(ir4), .out_data(od4), .out_carry(oc4), .out_err(oe4),
        .out_valid(ov4), .out_ready(or4), .shift_busy(bz4));

    wire [15:0] od = sel4 ? od4 : od1;
    wire        oc = sel4 ? oc4 : oc1;
    wire        oe = sel4 ? oe4 : oe1;
    wire        ov = sel4 ? ov4 : ov1;
    wire        ir = sel4 ? ir4 : ir1;
    wire        bz = sel4 ? bz4 : bz1;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        bit          i4;
        logic        src;
        logic [1:0]  f;
        logic [4:0]  sh;
        logic [15:0] av;
        logic [15:0] bv;
        exp_t        e;
    } tvec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Bit-at-a-time reference of the intended shift semantics.
    function automatic exp_t model(input logic [15:0] op, input logic [1:0] f, input int sh, input int step);
        exp_t e;
        int n;
        logic [15:0] d;
        logic c;
        d = op;
        c = 1'b0;
        e.err = 1'b0;
        n = 0;
        if (f == 2'b11) begin
`ifdef SHIFT_UNIT_ROTATE_EN
            n = sh % 16;
            for (int i = 0; i < n; i++) d = {d[14:0], d[15]};
`else
            e.err = 1'b1;
`endif
        end else begin
            n = (sh > 16) ? 16 : sh;
            for (int i = 0; i < n; i++) begin
                case (f)
                    2'b00:   begin c = d[0];  d = {1'b0, d[15:1]}; end
                    2'b01:   begin c = d[15]; d = {d[14:0], 1'b0}; end
                    default: begin c = d[0];  d = {d[15], d[15:1]}; end
                endcase
            end
            if (sh > 16 && f != 2'b10) c = 1'b0;
        end
        e.data  = d;
        e.carry = c;
        e.lat   = (n + step - 1) / step + 1;
        return e;
    endfunction

    // Presents a request with the unit idle; returns #1 after the accept edge with inputs scrambled.
    task automatic drive_accept(input bit i4, input logic src, input logic [1:0] f, input logic [4:0] sh,
                                input logic [15:0] av, input logic [15:0] bv);
        sel4 = i4; a = av; b = bv; src_sel = src; func = f; shamt = sh;
        #1;
        chk("in_ready_before_accept", {31'd0, ir}, 32'd1);
        if (i4) iv4 = 1'b1; else iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; iv4 = 1'b0;
        a = ~av; b = ~bv; func = ~f; shamt = ~sh;
    endtask

    task automatic wait_check(input string tag);
        int lat;
        exp_t e;
        lat = 1;
        while (!ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, ov}, 32'd1);
            chk({tag, "_data"},  {16'd0, od}, {16'd0, e.data});
            chk({tag, "_carry"}, {31'd0, oc}, {31'd0, e.carry});
            chk({tag, "_err"},   {31'd0, oe}, {31'd0, e.err});
            chk({tag, "_latency"}, lat, e.lat);
        end
    endtask

    task automatic handshake(input string tag);
        if (sel4) or4 = 1'b1; else or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0; or4 = 1'b0;
        chk({tag, "_post_hs_in_ready"}, {31'd0, ir}, 32'd1);
        chk({tag, "_post_hs_out_valid"}, {31'd0, ov}, 32'd0);
    endtask

    task automatic run_op(input string tag, input bit i4, input logic src, input logic [1:0] f,
                          input logic [4:0] sh, input logic [15:0] av, input logic [15:0] bv, input exp_t e);
        sb.push_back(e);
        drive_accept(i4, src, f, sh, av, bv);
        wait_check(tag);
        handshake(tag);
    endtask

    tvec_t tv[10];

    initial begin
        exp_t e;
        logic [15:0] hold_d;

        tv[0] = '{0, 0, 2'b00, 5'd1,  16'h8001, 16'h0000, '{16'h4000, 1'b1, 1'b0, 2}};
        tv[1] = '{1, 1, 2'b10, 5'd6,  16'hFFFF, 16'h8F00, '{16'hFE3C, 1'b0, 1'b0, 3}};
        tv[2] = '{0, 0, 2'b01, 5'd20, 16'hFFFF, 16'h0000, '{16'h0000, 1'b0, 1'b0, 17}};
        tv[3] = '{0, 0, 2'b00, 5'd0,  16'h1234, 16'h0000, '{16'h1234, 1'b0, 1'b0, 1}};
        tv[4] = '{0, 0, 2'b01, 5'd16, 16'h0001, 16'h0000, '{16'h0000, 1'b1, 1'b0, 17}};
        tv[5] = '{1, 0, 2'b10, 5'd16, 16'h8000, 16'h0000, '{16'hFFFF, 1'b1, 1'b0, 5}};
        tv[6] = '{1, 0, 2'b00, 5'd5,  16'h00F0, 16'h0000, '{16'h0007, 1'b1, 1'b0, 3}};
        tv[7] = '{1, 0, 2'b01, 5'd3,  16'h1234, 16'hFFFF, '{16'h91A0, 1'b0, 1'b0, 2}};
        tv[8] = '{0, 0, 2'b10, 5'd31, 16'h4000, 16'h0000, '{16'h0000, 1'b0, 1'b0, 17}};
`ifdef SHIFT_UNIT_ROTATE_EN
        tv[9] = '{0, 0, 2'b11, 5'd4,  16'h8001, 16'h0000, '{16'h0018, 1'b0, 1'b0, 5}};
`else
        tv[9] = '{0, 0, 2'b11, 5'd4,  16'h8001, 16'h0000, '{16'h8001, 1'b0, 1'b1, 1}};
`endif

        #12;
        chk("reset_in_ready_1", {31'd0, ir1}, 32'd1);
        chk("reset_in_ready_4", {31'd0, ir4}, 32'd1);
        chk("reset_outputs_1", {13'd0, ov1, oc1, oe1, od1}, 32'd0);
        chk("reset_outputs_4", {13'd0, ov4, oc4, oe4, od4}, 32'd0);
        chk("reset_busy", {30'd0, bz1, bz4}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), tv[i].i4, tv[i].src, tv[i].f, tv[i].sh, tv[i].av, tv[i].bv, tv[i].e);

        // Consumer stalls 5 cycles; a competing request must wait for the handshake.
        sb.push_back(model(16'h00F0, 2'b00, 2, 1));
        drive_accept(0, 0, 2'b00, 5'd2, 16'h00F0, 16'h0000);
        wait_check("stall_first");
        hold_d = od;
        a = 16'hABCD; src_sel = 1'b0; func = 2'b01; shamt = 5'd1; iv1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_valid_c%0d", c), {31'd0, ov}, 32'd1);
            chk($sformatf("stall_data_c%0d", c), {16'd0, od}, {16'd0, hold_d});
            chk($sformatf("stall_in_ready_c%0d", c), {31'd0, ir}, 32'd0);
        end
        or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        chk("stall_post_hs_in_ready", {31'd0, ir}, 32'd1);
        chk("stall_post_hs_valid", {31'd0, ov}, 32'd0);
        sb.push_back(model(16'hABCD, 2'b01, 1, 1));
        @(posedge clk); #1;
        iv1 = 1'b0; a = 16'h0000; func = 2'b00;
        chk("stall_second_busy", {31'd0, bz}, 32'd1);
        wait_check("stall_second");
        handshake("stall_second");

        // Reset in the middle of a long shift aborts it.
        drive_accept(0, 0, 2'b01, 5'd10, 16'h0F0F, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", {31'd0, bz}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, ir}, 32'd1);
        chk("abort_outputs", {12'd0, bz, ov, oc, oe, od}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_abort", 0, 0, 2'b00, 5'd3, 16'h0F0F, 16'h0000, model(16'h0F0F, 2'b00, 3, 1));

        for (int i = 0; i < 30; i++) begin
            bit          r4;
            logic        rs;
            logic [1:0]  rf;
            logic [4:0]  rsh;
            logic [15:0] ra, rb;
            r4  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            rf  = 2'($urandom_range(0, 3));
            rsh = 5'($urandom_range(0, 31));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            e   = model(rs ? rb : ra, rf, int'(rsh), r4 ? 4 : 1);
            run_op($sformatf("rand%0d", i), r4, rs, rf, rsh, ra, rb, e);
        end

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
